fifo_drain_arbiter: RTL and testbench

- Round-robin drain controller that shares one downstream consumer between NUM_FIFOS level-sensitive FIFO instances.
- Watches each FIFO's empty flag and head data, pops entries with single-cycle drop pulses, and presents them through a registered valid/ready output stage.
- Grants are held for bursts of up to BURST_LEN entries before rotating.
- Sits between a bank of per-requester FIFOs and a shared sink (bus master, UART TX, etc.).

---
 rtl/fifo_drain_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain of NUM_FIFOS source FIFOs into one
// registered valid/ready sink, holding each grant for up to BURST_LEN entries.
// Optional macro FIFO_DRAIN_ARB_PRIO_EN adds prio_i; when any flagged source is
// non-empty, the next grant is chosen only among the flagged sources.
module fifo_drain_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FIFOS-1:0]            fifo_empty_i,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_i,
`ifdef FIFO_DRAIN_ARB_PRIO_EN
  input  logic [NUM_FIFOS-1:0]            prio_i,
`endif
  output logic [NUM_FIFOS-1:0]            fifo_drop_o,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [IDX_WIDTH-1:0]            out_src,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            grant_valid,
  output logic [IDX_WIDTH-1:0]            grant_idx
);

  localparam int unsigned          CNT_WIDTH = $clog2(BURST_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_FIFOS - 1);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  burst_cnt;
  logic [IDX_WIDTH-1:0]  last_served;
  logic [DATA_WIDTH-1:0] head [NUM_FIFOS];
  logic [NUM_FIFOS-1:0]  req_c;
  logic [IDX_WIDTH-1:0]  pick_c;
  logic [IDX_WIDTH-1:0]  rr_cand;
  logic                  rr_found;
  logic                  any_req_c;
  logic                  load_en_c;
  logic                  head_empty_c;
  logic                  burst_end_c;
  logic                  pop_c;
  logic                  leave_c;

  // Unpack the flat head bus into one entry per source
  always_comb begin
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      head[k] = fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Candidate set for the next grant; flagged sources shadow the rest when present
  always_comb begin
    req_c = ~fifo_empty_i;
`ifdef FIFO_DRAIN_ARB_PRIO_EN
    if (|(~fifo_empty_i & prio_i)) begin
      req_c = ~fifo_empty_i & prio_i;
    end
`endif
  end

  // Round-robin search starting just after the last served source
  always_comb begin
    pick_c   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int unsigned i = 1; i <= NUM_FIFOS; i++) begin
      rr_cand = IDX_WIDTH'((32'(last_served) + i) % NUM_FIFOS);
      if (!rr_found && req_c[rr_cand]) begin
        pick_c   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  assign any_req_c    = |req_c;
  assign load_en_c    = ~out_valid | out_ready;
  assign head_empty_c = fifo_empty_i[grant_idx];
  assign burst_end_c  = (burst_cnt == LAST_BEAT);
  assign pop_c        = (state == SERVE) & load_en_c & ~head_empty_c & ~rst;
  assign leave_c      = (state == SERVE) & load_en_c & (head_empty_c | burst_end_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one IDLE cycle per grant, SERVE until burst limit or source runs dry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req_c) state_nxt = SERVE;
      SERVE: if (leave_c)   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: pop pulse for the granted source only
  always_comb begin
    fifo_drop_o = '0;
    grant_valid = (state == SERVE);
    if (pop_c) fifo_drop_o[grant_idx] = 1'b1;
  end

  // Grant, burst count, fairness pointer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt   <= '0;
      last_served <= LAST_IDX;
      grant_idx   <= '0;
      out_data    <= '0;
      out_src     <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if ((state == IDLE) && any_req_c) begin
        grant_idx <= pick_c;
        burst_cnt <= '0;
      end
      if (pop_c) begin
        out_data  <= head[grant_idx];
        out_src   <= grant_idx;
        out_valid <= 1'b1;
        burst_cnt <= burst_cnt + CNT_WIDTH'(1);
      end
      if (leave_c) last_served <= grant_idx;
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: bench for fifo_drain_arbiter with queue-backed source
// FIFOs, a transaction-level expected-order model and per-cycle output checks.
module tb_fifo_drain_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
  } ent_t;

  logic             clk;
  logic             rst;
  logic [NF-1:0]    fifo_empty_i;
  logic [NF*DW-1:0] fifo_data_i;
  logic [NF-1:0]    fifo_drop_o;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_src;
  logic             out_valid;
  logic             out_ready;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;
`ifdef FIFO_DRAIN_ARB_PRIO_EN
  logic [NF-1:0]    prio_i;
`endif

  fifo_drain_arbiter #(
    .DATA_WIDTH(DW), .NUM_FIFOS(NF), .BURST_LEN(BL), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
`ifdef FIFO_DRAIN_ARB_PRIO_EN
    .prio_i(prio_i),
`endif
    .fifo_drop_o(fifo_drop_o),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO contents as seen by the DUT, and the model's private copy
  logic [DW-1:0] fq [NF][$];
  logic [DW-1:0] mq [NF][$];
  ent_t          exp_q [$];
  int            pop_cnt [NF];
  int            total = 0;
  int            bad = 0;
  int            busy_cnt = 0;
  int            pred_cycles = 0;
  int            m_last = NF - 1;
  logic [NF-1:0] mprio = '0;
  logic          prev_ov = 1'b0;
  logic          prev_rdy = 1'b0;
  logic          prev_rst = 1'b1;
  ent_t          prev_ent = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int fifo_count();
    int s = 0;
    for (int k = 0; k < NF; k++) s += fq[k].size();
    return s;
  endfunction

  function automatic void refresh();
    for (int k = 0; k < NF; k++) begin
      fifo_empty_i[k] = (fq[k].size() == 0);
      fifo_data_i[k*DW +: DW] = (fq[k].size() == 0) ? (32'hDEAD0000 | 32'(k)) : fq[k][0];
    end
  endfunction

  // Expected transfer order: grant-by-grant, each grant drains min(BL, depth)
  task automatic build_expected();
    logic [NF-1:0] elig;
    int            g;
    int            n;
    int            left;
    ent_t          t;
    left = 0;
    for (int k = 0; k < NF; k++) left += mq[k].size();
    while (left > 0) begin
      for (int k = 0; k < NF; k++) elig[k] = (mq[k].size() != 0);
      if ((elig & mprio) != '0) elig = elig & mprio;
      g = -1;
      for (int step = 1; step <= int'(NF) && g < 0; step++) begin
        if (elig[(m_last + step) % int'(NF)]) g = (m_last + step) % int'(NF);
      end
      n = (mq[g].size() < int'(BL)) ? mq[g].size() : int'(BL);
      for (int j = 0; j < n; j++) begin
        t.src  = IW'(g);
        t.data = mq[g].pop_front();
        exp_q.push_back(t);
      end
      pred_cycles += 1 + n + ((n < int'(BL)) ? 1 : 0);
      m_last = g;
      left -= n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int k, input logic [DW-1:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      fq[k].push_back(base + DW'(j));
      mq[k].push_back(base + DW'(j));
    end
  endtask

  task automatic start_run();
    pred_cycles = 0;
    busy_cnt = 0;
    for (int k = 0; k < NF; k++) pop_cnt[k] = 0;
    build_expected();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_last = NF - 1;
  endtask

  task automatic wait_pops(input string name, input int k, input int n);
    int c = 0;
    while (pop_cnt[k] < n && c < 50) begin
      tick();
      c++;
    end
    check({name, "_pops_seen"}, 64'(pop_cnt[k]), 64'(n));
  endtask

  task automatic wait_drain(input string name, input int extra);
    int c = 0;
    while ((fifo_count() != 0 || grant_valid || out_valid) && c < 500) begin
      tick();
      c++;
    end
    check({name, "_drained"}, 64'(c < 500), 64'd1);
    check({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_cycles"}, 64'(busy_cnt), 64'(pred_cycles + extra));
  endtask

  // Source FIFO behaviour: pop at the edge ending a cycle with drop set
  initial begin : fifo_side
    logic [NF-1:0] d;
    refresh();
    forever begin
      @(posedge clk);
      d = fifo_drop_o;
      #1;
      for (int k = 0; k < NF; k++) begin
        if (d[k] && fq[k].size() != 0) begin
          void'(fq[k].pop_front());
          pop_cnt[k]++;
        end
      end
      refresh();
      #2;
      refresh();
    end
  end

  // Per-cycle output checks and scoreboard, sampled mid-cycle
  always @(negedge clk) begin : compare
    ent_t got;
    ent_t e;
    got.src  = out_src;
    got.data = out_data;
    check("drop_onehot0", 64'($onehot0(fifo_drop_o)), 64'd1);
    if (rst) check("drop_in_rst", 64'(fifo_drop_o), 64'd0);
    if (fifo_drop_o != '0) begin
      check("drop_vs_grant", 64'(fifo_drop_o), 64'(1) << grant_idx);
      check("drop_grant_valid", 64'(grant_valid), 64'd1);
      check("drop_nonempty", 64'(fifo_drop_o & fifo_empty_i), 64'd0);
    end
    if (out_valid && !out_ready) check("drop_stalled", 64'(fifo_drop_o), 64'd0);
    if (prev_ov && !prev_rdy && !prev_rst) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_entry", 64'(got), 64'(prev_ent));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_entry", 64'(got), 64'(e));
      end
    end
    if (!rst && (grant_valid || fifo_count() != 0)) busy_cnt++;
    prev_ov  = out_valid;
    prev_rdy = out_ready;
    prev_rst = rst;
    prev_ent = got;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no completion expected finish before t=100000");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    rst = 1'b1;
    out_ready = 1'b1;
`ifdef FIFO_DRAIN_ARB_PRIO_EN
    prio_i = '0;
`endif
    tick();
    tick();

    // Reset held with every source non-empty
    load(0, 32'h100, 1);
    load(1, 32'h110, 1);
    load(2, 32'h120, 1);
    load(3, 32'h130, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_drop", 64'(fifo_drop_o), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_src", 64'(out_src), 64'd0);
      check("rst_grant_valid", 64'(grant_valid), 64'd0);
      check("rst_grant_idx", 64'(grant_idx), 64'd0);
    end
    rst = 1'b0;
    m_last = NF - 1;
    start_run();
    tick();
    check("rst_first_grant_valid", 64'(grant_valid), 64'd1);
    check("rst_first_grant_idx", 64'(grant_idx), 64'd0);
    wait_drain("reset_release", 0);
    check("reset_release_lit_cycles", 64'(busy_cnt), 64'd12);

    // Single source with three entries
    do_reset();
    load(2, 32'hA, 3);
    start_run();
    check("single_idle", 64'(grant_valid), 64'd0);
    tick();
    check("single_drop1", 64'(fifo_drop_o), 64'b0100);
    check("single_grant", 64'(grant_idx), 64'd2);
    tick();
    check("single_drop2", 64'(fifo_drop_o), 64'b0100);
    check("single_data_a", 64'({out_valid, out_src, out_data}), {31'd0, 1'b1, 2'd2, 32'hA});
    tick();
    check("single_drop3", 64'(fifo_drop_o), 64'b0100);
    check("single_data_b", 64'({out_valid, out_src, out_data}), {31'd0, 1'b1, 2'd2, 32'hB});
    tick();
    check("single_drop_done", 64'(fifo_drop_o), 64'd0);
    check("single_serve_empty", 64'(grant_valid), 64'd1);
    check("single_data_c", 64'({out_valid, out_src, out_data}), {31'd0, 1'b1, 2'd2, 32'hC});
    tick();
    check("single_back_idle", 64'(grant_valid), 64'd0);
    wait_drain("single", 0);
    check("single_lit_cycles", 64'(busy_cnt), 64'd5);

    // Fairness pointer continues after source 2
    load(1, 32'h11, 1);
    load(3, 32'h33, 1);
    start_run();
    tick();
    check("after2_grant_idx", 64'(grant_idx), 64'd3);
    wait_drain("after2", 0);

    // Fairness across four sources of six entries each
    do_reset();
    for (int k = 0; k < NF; k++) load(k, DW'(k) << 8, 6);
    start_run();
    wait_drain("fair", 0);
    check("fair_lit_cycles", 64'(busy_cnt), 64'd36);

    // Backpressure for five cycles mid-burst
    do_reset();
    load(0, 32'h400, 4);
    load(1, 32'h410, 2);
    start_run();
    wait_pops("bp", 0, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_drop_held", 64'(fifo_drop_o), 64'd0);
      check("bp_entry_held", 64'({out_valid, out_src, out_data}), {31'd0, 1'b1, 2'd0, 32'h401});
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp", 5);

    // Reset after two of four entries from source 1
    do_reset();
    load(1, 32'h50, 4);
    for (int k = 0; k < NF; k++) begin
      while (mq[k].size() != 0) void'(mq[k].pop_front());
    end
    begin
      ent_t t;
      t.src = 2'd1;
      t.data = 32'h50;
      exp_q.push_back(t);
    end
    for (int k = 0; k < NF; k++) pop_cnt[k] = 0;
    wait_pops("midrst", 1, 2);
    rst = 1'b1;
    load(0, 32'h60, 2);
    #1;
    check("midrst_drop_gated", 64'(fifo_drop_o), 64'd0);
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_grant_valid", 64'(grant_valid), 64'd0);
    check("midrst_no_more_pops", 64'(pop_cnt[1]), 64'd2);
    check("midrst_src1_left", 64'(fq[1].size()), 64'd2);
    rst = 1'b0;
    m_last = NF - 1;
    for (int k = 0; k < NF; k++) begin
      while (mq[k].size() != 0) void'(mq[k].pop_front());
    end
    mq[1].push_back(32'h52);
    mq[1].push_back(32'h53);
    mq[0].push_back(32'h60);
    mq[0].push_back(32'h61);
    start_run();
    tick();
    check("midrst_next_grant", 64'(grant_idx), 64'd0);
    wait_drain("midrst", 0);

`ifdef FIFO_DRAIN_ARB_PRIO_EN
    // Priority subset: source 3 keeps the grant until empty
    do_reset();
    prio_i = 4'b1000;
    mprio = 4'b1000;
    for (int k = 0; k < NF; k++) load(k, 32'h700 | (DW'(k) << 4), 6);
    start_run();
    tick();
    check("prio_first_grant", 64'(grant_idx), 64'd3);
    wait_drain("prio", 0);
    check("prio_lit_cycles", 64'(busy_cnt), 64'd36);
    prio_i = '0;
    mprio = '0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
